// File: rtl/riscv_core_branch_predictor_if.sv
// Fetch/EX-facing signal bundle for the bimodal branch predictor.
// master = core pipeline side, slave = predictor.
interface riscv_core_branch_predictor_if #(
    parameter int XLEN = 64
);
    logic            i_bp_fetch_valid;
    logic [XLEN-1:0] i_bp_fetch_pc;
    logic            o_bp_predict_taken;
    logic            i_bp_resolve_valid;
    logic [XLEN-1:0] i_bp_resolve_pc;
    logic            i_bp_resolve_istaken;
    logic            i_bp_resolve_predicted;
    logic [XLEN-1:0] i_bp_resolve_target;
    logic [XLEN-1:0] i_bp_resolve_pc_next;
    logic            o_bp_flush;
    logic [XLEN-1:0] o_bp_redirect_pc;
    logic [31:0]     o_bp_mispredict_cnt;

    modport master (
        output i_bp_fetch_valid, i_bp_fetch_pc,
        output i_bp_resolve_valid, i_bp_resolve_pc, i_bp_resolve_istaken,
        output i_bp_resolve_predicted, i_bp_resolve_target, i_bp_resolve_pc_next,
        input  o_bp_predict_taken, o_bp_flush, o_bp_redirect_pc, o_bp_mispredict_cnt
    );

    modport slave (
        input  i_bp_fetch_valid, i_bp_fetch_pc,
        input  i_bp_resolve_valid, i_bp_resolve_pc, i_bp_resolve_istaken,
        input  i_bp_resolve_predicted, i_bp_resolve_target, i_bp_resolve_pc_next,
        output o_bp_predict_taken, o_bp_flush, o_bp_redirect_pc, o_bp_mispredict_cnt
    );
endinterface

// File: rtl/riscv_core_branch_predictor.sv
// Bimodal 2-bit-counter branch predictor with registered mispredict flush/redirect.
// Define RISCV_CORE_BP_GSHARE_EN to XOR a global history register into the index.
module riscv_core_branch_predictor #(
    parameter int XLEN        = 64,
    parameter int BHT_ENTRIES = 64,
    parameter int IDX_LSB     = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    riscv_core_branch_predictor_if.slave  bp
);
    localparam int IW = $clog2(BHT_ENTRIES);

    logic [BHT_ENTRIES-1:0][1:0] bht;
    logic [IW-1:0]               fetch_idx;
    logic [IW-1:0]               res_idx;
    logic [1:0]                  cur_ctr;
    logic [1:0]                  nxt_ctr;
    logic                        accept;
    logic                        mispredict;
    logic                        flush;
    logic [XLEN-1:0]             redirect_pc;
    logic [31:0]                 miss_cnt;

`ifdef RISCV_CORE_BP_GSHARE_EN
    logic [IW-1:0] ghr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            ghr <= '0;
        else if (accept)
            ghr <= {ghr[IW-2:0], bp.i_bp_resolve_istaken};
    end

    assign fetch_idx = bp.i_bp_fetch_pc[IDX_LSB +: IW] ^ ghr;
    assign res_idx   = bp.i_bp_resolve_pc[IDX_LSB +: IW] ^ ghr;
`else
    assign fetch_idx = bp.i_bp_fetch_pc[IDX_LSB +: IW];
    assign res_idx   = bp.i_bp_resolve_pc[IDX_LSB +: IW];
`endif

    // Resolves landing in the flush cycle belong to the squashed wrong path.
    assign accept     = bp.i_bp_resolve_valid & ~flush;
    assign mispredict = accept & (bp.i_bp_resolve_istaken != bp.i_bp_resolve_predicted);
    assign cur_ctr    = bht[res_idx];

    always_comb begin
        nxt_ctr = cur_ctr;
        if (bp.i_bp_resolve_istaken) begin
            if (cur_ctr != 2'b11) nxt_ctr = cur_ctr + 2'b01;
        end else begin
            if (cur_ctr != 2'b00) nxt_ctr = cur_ctr - 2'b01;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht[i] <= 2'b01;
        end else if (accept) begin
            bht[res_idx] <= nxt_ctr;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            flush       <= 1'b0;
            redirect_pc <= '0;
            miss_cnt    <= '0;
        end else begin
            flush <= mispredict;
            if (mispredict) begin
                redirect_pc <= bp.i_bp_resolve_istaken ? bp.i_bp_resolve_target
                                                       : bp.i_bp_resolve_pc_next;
                if (miss_cnt != 32'hFFFF_FFFF)
                    miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

    // No write bypass: a same-cycle lookup sees the pre-update counter.
    assign bp.o_bp_predict_taken  = bp.i_bp_fetch_valid & bht[fetch_idx][1];
    assign bp.o_bp_flush          = flush;
    assign bp.o_bp_redirect_pc    = redirect_pc;
    assign bp.o_bp_mispredict_cnt = miss_cnt;
endmodule

// File: tb/tb_riscv_core_branch_predictor.sv
// Directed table-driven bench for the branch predictor (default bimodal build).
module tb_riscv_core_branch_predictor;
    localparam int XLEN = 64;

    logic i_clk;
    logic i_rst_n;
    int   checks;
    int   failures;

    riscv_core_branch_predictor_if #(.XLEN(XLEN)) bp ();

    riscv_core_branch_predictor #(
        .XLEN(XLEN), .BHT_ENTRIES(64), .IDX_LSB(1)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bp     (bp.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        fv;
        logic [63:0] fpc;
        logic        rv;
        logic [63:0] rpc;
        logic        tk;
        logic        pr;
        logic [63:0] tgt;
        logic [63:0] nxt;
        logic        exp_pred;
        logic        exp_flush;
        logic [63:0] exp_redir;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vec [14];

    function automatic vec_t mk(logic fv, logic [63:0] fpc, logic rv, logic [63:0] rpc,
                                logic tk, logic pr, logic [63:0] tgt, logic [63:0] nxt,
                                logic ep, logic ef, logic [63:0] er, logic [31:0] ec);
        vec_t v;
        v.fv = fv; v.fpc = fpc; v.rv = rv; v.rpc = rpc; v.tk = tk; v.pr = pr;
        v.tgt = tgt; v.nxt = nxt; v.exp_pred = ep; v.exp_flush = ef;
        v.exp_redir = er; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [63:0] fpc, input logic rv,
                         input logic [63:0] rpc, input logic tk, input logic pr,
                         input logic [63:0] tgt, input logic [63:0] nxt);
        bp.i_bp_fetch_valid       = fv;
        bp.i_bp_fetch_pc          = fpc;
        bp.i_bp_resolve_valid     = rv;
        bp.i_bp_resolve_pc        = rpc;
        bp.i_bp_resolve_istaken   = tk;
        bp.i_bp_resolve_predicted = pr;
        bp.i_bp_resolve_target    = tgt;
        bp.i_bp_resolve_pc_next   = nxt;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        // idx(0x80)=0, idx(0x40)=32, idx(0x20)=16, idx(0x10)=8, idx(0x30)=24, idx(0x50)=40
        vec[0]  = mk(1, 64'h80, 0, 64'h0,  0, 0, 64'h0,   64'h0,  0, 0, 64'h0,   32'd0);
        vec[1]  = mk(1, 64'h80, 1, 64'h80, 1, 0, 64'h100, 64'h84, 0, 1, 64'h100, 32'd1);
        vec[2]  = mk(1, 64'h80, 0, 64'h0,  0, 0, 64'h0,   64'h0,  1, 0, 64'h100, 32'd1);
        vec[3]  = mk(1, 64'h80, 1, 64'h80, 1, 1, 64'h100, 64'h84, 1, 0, 64'h100, 32'd1);
        vec[4]  = mk(1, 64'h80, 1, 64'h80, 1, 1, 64'h100, 64'h84, 1, 0, 64'h100, 32'd1);
        vec[5]  = mk(1, 64'h80, 1, 64'h80, 1, 1, 64'h100, 64'h84, 1, 0, 64'h100, 32'd1);
        vec[6]  = mk(1, 64'h80, 0, 64'h0,  0, 0, 64'h0,   64'h0,  1, 0, 64'h100, 32'd1);
        vec[7]  = mk(1, 64'h80, 1, 64'h80, 0, 1, 64'h100, 64'h84, 1, 1, 64'h84,  32'd2);
        vec[8]  = mk(1, 64'h80, 0, 64'h0,  0, 0, 64'h0,   64'h0,  1, 0, 64'h84,  32'd2);
        vec[9]  = mk(1, 64'h40, 1, 64'h40, 0, 0, 64'h900, 64'h44, 0, 0, 64'h84,  32'd2);
        vec[10] = mk(1, 64'h40, 1, 64'h40, 0, 0, 64'h900, 64'h44, 0, 0, 64'h84,  32'd2);
        vec[11] = mk(1, 64'h40, 1, 64'h40, 0, 0, 64'h900, 64'h44, 0, 0, 64'h84,  32'd2);
        vec[12] = mk(1, 64'h40, 1, 64'h40, 0, 0, 64'h900, 64'h44, 0, 0, 64'h84,  32'd2);
        vec[13] = mk(0, 64'h40, 0, 64'h0,  0, 0, 64'h0,   64'h0,  0, 0, 64'h84,  32'd2);

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_flush", 64'(bp.o_bp_flush), 64'h0);
        chk("reset_redirect", bp.o_bp_redirect_pc, 64'h0);
        chk("reset_cnt", 64'(bp.o_bp_mispredict_cnt), 64'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            drive(vec[i].fv, vec[i].fpc, vec[i].rv, vec[i].rpc,
                  vec[i].tk, vec[i].pr, vec[i].tgt, vec[i].nxt);
            #1;
            chk($sformatf("v%0d_pred", i), 64'(bp.o_bp_predict_taken), 64'(vec[i].exp_pred));
            step();
            chk($sformatf("v%0d_flush", i), 64'(bp.o_bp_flush), 64'(vec[i].exp_flush));
            chk($sformatf("v%0d_redir", i), bp.o_bp_redirect_pc, vec[i].exp_redir);
            chk($sformatf("v%0d_cnt", i), 64'(bp.o_bp_mispredict_cnt), 64'(vec[i].exp_cnt));
        end
        // 0x40 lookup after saturation at strong-NT
        drive(1, 64'h40, 0, 0, 0, 0, 0, 0);
        #1;
        chk("sat_nt_pred", 64'(bp.o_bp_predict_taken), 64'h0);
        step();

        // Wrong-path squash: second mispredict in the flush cycle is ignored.
        drive(0, 0, 1, 64'h10, 1, 0, 64'h200, 64'h14);
        step();
        chk("sq_flush1", 64'(bp.o_bp_flush), 64'h1);
        chk("sq_redir1", bp.o_bp_redirect_pc, 64'h200);
        chk("sq_cnt1", 64'(bp.o_bp_mispredict_cnt), 64'd3);
        drive(0, 0, 1, 64'h30, 1, 0, 64'h300, 64'h34);
        step();
        chk("sq_flush2", 64'(bp.o_bp_flush), 64'h0);
        chk("sq_redir2", bp.o_bp_redirect_pc, 64'h200);
        chk("sq_cnt2", 64'(bp.o_bp_mispredict_cnt), 64'd3);
        drive(1, 64'h30, 0, 0, 0, 0, 0, 0);
        #1;
        chk("sq_untrained_pred", 64'(bp.o_bp_predict_taken), 64'h0);
        drive(1, 64'h10, 0, 0, 0, 0, 0, 0);
        #1;
        chk("sq_trained_pred", 64'(bp.o_bp_predict_taken), 64'h1);
        step();

        // Same-cycle lookup and update: no bypass.
        drive(1, 64'h20, 1, 64'h20, 1, 0, 64'h400, 64'h24);
        #1;
        chk("byp_old_pred", 64'(bp.o_bp_predict_taken), 64'h0);
        step();
        chk("byp_flush", 64'(bp.o_bp_flush), 64'h1);
        chk("byp_redir", bp.o_bp_redirect_pc, 64'h400);
        chk("byp_cnt", 64'(bp.o_bp_mispredict_cnt), 64'd4);
        drive(1, 64'h20, 0, 0, 0, 0, 0, 0);
        #1;
        chk("byp_new_pred", 64'(bp.o_bp_predict_taken), 64'h1);
        step();

        // Counter saturation at all-ones, then async reset mid-flush.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        force dut.miss_cnt = 32'hFFFF_FFFF;
        step();
        release dut.miss_cnt;
        #1;
        chk("sat_forced", 64'(bp.o_bp_mispredict_cnt), 64'hFFFF_FFFF);
        drive(0, 0, 1, 64'h50, 1, 0, 64'h500, 64'h54);
        step();
        drive(1, 64'h80, 0, 0, 0, 0, 0, 0);
        #1;
        chk("sat_flush", 64'(bp.o_bp_flush), 64'h1);
        chk("sat_redir", bp.o_bp_redirect_pc, 64'h500);
        chk("sat_cnt", 64'(bp.o_bp_mispredict_cnt), 64'hFFFF_FFFF);
        chk("pre_rst_pred", 64'(bp.o_bp_predict_taken), 64'h1);
        i_rst_n = 1'b0;
        #1;
        chk("arst_flush", 64'(bp.o_bp_flush), 64'h0);
        chk("arst_redir", bp.o_bp_redirect_pc, 64'h0);
        chk("arst_cnt", 64'(bp.o_bp_mispredict_cnt), 64'h0);
        chk("arst_pred", 64'(bp.o_bp_predict_taken), 64'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();
        chk("post_rst_flush", 64'(bp.o_bp_flush), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
